// File: rtl/shift_sub_divider.sv
// shift_sub_divider
// Sequential restoring (shift-and-subtract) unsigned divider. Operands arrive
// on one shared bus: the dividend in the cycle start is accepted, the divisor
// on the following cycle. One quotient bit is produced per clock, MSB first.
// The results are registered and held until the next result is produced.
//
// Optional feature: define DIV_ZERO_DETECT_EN to detect divide-by-zero.
// A zero divisor then skips the iterations and raises dbz. Without the macro,
// dbz is tied low and the iterations always run.
//
// Ports:
//   i_clk       rising-edge clock
//   i_rst_n     asynchronous active-low reset
//   start       request a division (sampled only in IDLE)
//   data_input  shared operand bus: dividend, then divisor on the next cycle
//   quotient    registered quotient, held until the next result
//   remainder   registered remainder, held until the next result
//   done        one-cycle pulse in the DONE state
//   busy        high in LOAD_B and CALC
//   dbz         divide-by-zero flag, updated with the results
//   p_STATE     current state: IDLE=0, LOAD_B=1, CALC=2, DONE=3
module shift_sub_divider #(
  parameter int D_WIDTH     = 8,
  parameter int State_WIDTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   start,
  input  logic [D_WIDTH-1:0]     data_input,
  output logic [D_WIDTH-1:0]     quotient,
  output logic [D_WIDTH-1:0]     remainder,
  output logic                   done,
  output logic                   busy,
  output logic                   dbz,
  output logic [State_WIDTH-1:0] p_STATE
);

  localparam int CW = $clog2(D_WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_B = 2'd1,
    S_CALC   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             r_state;
  logic [D_WIDTH-1:0] r_dividend;
  logic [D_WIDTH-1:0] r_divisor;
  // The partial remainder is always below the divisor after each step, so
  // D_WIDTH bits hold it; the extra bit only exists in the trial value.
  logic [D_WIDTH-1:0] r_rem;
  logic [D_WIDTH-1:0] r_quot;
  logic [CW-1:0]      r_count;
`ifdef DIV_ZERO_DETECT_EN
  logic               r_dbz;
`endif

  logic [D_WIDTH:0]   w_trial;
  logic               w_ge;
  logic [D_WIDTH-1:0] w_rem_next;
  logic [D_WIDTH-1:0] w_quot_next;
  logic               w_last;

  // Trial value: remainder shifted left with the next dividend bit appended.
  assign w_trial     = {r_rem, r_dividend[D_WIDTH-1]};
  assign w_ge        = (w_trial >= {1'b0, r_divisor});
  // When w_ge holds, the difference is below the divisor, so modulo-2^D_WIDTH
  // subtraction on the low bits gives the exact result.
  assign w_rem_next  = w_ge ? (w_trial[D_WIDTH-1:0] - r_divisor) : w_trial[D_WIDTH-1:0];
  assign w_quot_next = {r_quot[D_WIDTH-2:0], w_ge};
  assign w_last      = (r_count == CW'(D_WIDTH - 1));

  assign p_STATE = State_WIDTH'(r_state);

`ifdef DIV_ZERO_DETECT_EN
  assign dbz = r_dbz;
`else
  assign dbz = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_quot     <= '0;
      r_count    <= '0;
      quotient   <= '0;
      remainder  <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      r_dbz      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dividend <= data_input;
            busy       <= 1'b1;
            r_state    <= S_LOAD_B;
          end
        end

        S_LOAD_B: begin
          r_divisor <= data_input;
          r_rem     <= '0;
          r_quot    <= '0;
          r_count   <= '0;
`ifdef DIV_ZERO_DETECT_EN
          if (data_input == '0) begin
            // Same values the iterations would produce, without running them.
            quotient  <= '1;
            remainder <= r_dividend;
            r_dbz     <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
            r_state   <= S_DONE;
          end else begin
            r_state <= S_CALC;
          end
`else
          r_state <= S_CALC;
`endif
        end

        S_CALC: begin
          r_rem      <= w_rem_next;
          r_quot     <= w_quot_next;
          r_dividend <= {r_dividend[D_WIDTH-2:0], 1'b0};
          r_count    <= r_count + 1'b1;
          if (w_last) begin
            quotient  <= w_quot_next;
            remainder <= w_rem_next;
`ifdef DIV_ZERO_DETECT_EN
            r_dbz     <= 1'b0;
`endif
            done      <= 1'b1;
            busy      <= 1'b0;
            r_state   <= S_DONE;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/shift_sub_divider.md
# shift_sub_divider

Sequential restoring (shift-and-subtract) unsigned divider: the inverse of the team's shift-and-add accumulator multiplier. It uses the same start/serial-operand-load protocol on one shared input bus, and it is built as one module containing a datapath plus a controller FSM. It sits beside the multiplier in the arithmetic test platform. It accepts dividend then divisor on consecutive cycles, iterates one quotient bit per clock, and presents registered quotient/remainder with a one-cycle done pulse.

## Interface
- D_WIDTH, 8, operand/result width; iteration count equals D_WIDTH
- State_WIDTH, 4, width of the state-observation port
- i_clk  input  1  rising-edge clock
- i_rst_n  input  1  reset, asynchronous and active-low; one clock, no other clock domains
- start  input  1  request a division; sampled only in IDLE
- data_input  input  D_WIDTH  shared operand bus: dividend, then divisor on the next cycle
- quotient  output  D_WIDTH  registered result, held until the next result
- remainder  output  D_WIDTH  registered result, held until the next result
- done  output  1  one-cycle pulse; results valid from this cycle onward
- busy  output  1  high in LOAD_B and CALC
- dbz  output  1  divide-by-zero flag, updated with the results (feature-dependent)
- p_STATE  output  State_WIDTH  current state: IDLE=0, LOAD_B=1, CALC=2, DONE=3

## Operation
- Reset (async assert, sync release) clears everything: state=IDLE; quotient, remainder, done, busy, dbz = 0; internal registers = 0.
- IDLE: at an edge with start=1, dividend register <= data_input and state -> LOAD_B. At an edge with start=0, stay in IDLE.
- LOAD_B: on the next edge, unconditionally:
  - divisor <= data_input
  - partial remainder R (D_WIDTH+1 bits) <= 0
  - iteration counter <= 0
  - state -> CALC, or -> DONE directly when the divide-by-zero feature is enabled and divisor=0
- CALC, one iteration per edge, MSB first:
  - T = {R[D_WIDTH-1:0], dividend MSB}; dividend shifts left by one.
  - If T >= {0, divisor}: R <= T - divisor and shift 1 into the quotient LSB. Otherwise R <= T and shift 0 in.
  - The compare is unsigned at D_WIDTH+1 bits, so no overflow is possible.
  - After D_WIDTH iterations, state -> DONE and the output registers load: quotient from the working quotient, remainder from R[D_WIDTH-1:0], dbz.
- DONE: done=1 for exactly this cycle, then IDLE on the next edge. start is ignored in DONE.
- start is ignored in LOAD_B, CALC and DONE, and does not queue.
- quotient/remainder/dbz hold their previous values throughout a new operation until the next DONE entry.
- Reset mid-operation aborts immediately, returns to IDLE and clears the outputs. There is no partial result.

## Timing
- Edge e0: start seen in IDLE, dividend captured. Edge e1: divisor captured.
- Edges e2..e(D_WIDTH+1): iterations; the last one enters DONE.
- For D_WIDTH=8:
  - done is high in the cycle after e9, i.e. 10 edges after start is sampled.
  - Next accepted start is at e11 earliest, since e10 leaves DONE.
- Divide-by-zero fast path (feature enabled): DONE is entered at e1 and done is high in the cycle after e1.
- busy is high from the cycle after e0 until DONE is entered. It is low in DONE and IDLE.
- start held permanently high gives back-to-back operations every D_WIDTH+3 edges.

## Configuration
- DIV_ZERO_DETECT_EN defined:
  - divisor=0 skips CALC
  - quotient = all ones, remainder = dividend, dbz=1
  - done 2 edges after start
  - a nonzero divisor gives dbz=0
- Not defined:
  - no zero check; CALC always runs D_WIDTH iterations
  - the natural algorithm still yields quotient = all ones, remainder = dividend
  - dbz is tied 0
  - latency is constant at D_WIDTH+2 edges

## Test plan
- Reset asserted asynchronously mid-cycle: all outputs are 0 and p_STATE=0 immediately, with no clock needed.
- start, then dividend 200, then divisor 7: quotient=28, remainder=4, done is a single pulse 10 edges after start, and busy is high for 9 cycles.
- Dividend 3, divisor 12: quotient=0, remainder=3. Then dividend 255, divisor 1: quotient=255, remainder=0.
- Dividend 0x5A, divisor 0:
  - With DIV_ZERO_DETECT_EN: quotient=0xFF, remainder=0x5A, dbz=1, done 2 edges after start.
  - Without it: same quotient and remainder, dbz=0, done at 10 edges.
- Reset pulsed during CALC of 200/7: the FSM returns to IDLE, outputs are 0, and no done pulse occurs. A fresh 100/9 then gives quotient=11, remainder=1.
- start held high with new operands each operation: start is ignored while busy, operations repeat every 11 edges, and results stay stable between done pulses.
